// File: rtl/mm_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped peripheral bus among NUM_CORES cores.
// One transaction in flight; a missing bus_ack aborts after TIMEOUT_CYC cycles with an error response.
module mm_bus_arbiter #(
  parameter int          NUM_CORES   = 2,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [15:0] ERR_RDATA   = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CORES-1:0]         req_re,
  input  logic [NUM_CORES-1:0]         req_we,
  input  logic [16*NUM_CORES-1:0]      req_addr,
  input  logic [16*NUM_CORES-1:0]      req_wdata,
  output logic [NUM_CORES-1:0]         rsp_rdy,
  output logic                         rsp_err,
  output logic [15:0]                  rsp_rdata,
  output logic [15:0]                  bus_addr,
  output logic                         bus_re,
  output logic                         bus_we,
  output logic [15:0]                  bus_wdata,
  input  logic [15:0]                  bus_rdata,
  input  logic                         bus_ack,
  output logic [$clog2(NUM_CORES)-1:0] grant_id
);

  localparam int IW = $clog2(NUM_CORES);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            op_wr_q, op_wr_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [NUM_CORES-1:0] req_any;
  logic [IW-1:0]        win;
  logic                 found;

  assign req_any = req_re | req_we;

  // First requester at or after rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_CORES;
      if (!found && req_any[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    op_wr_d  = op_wr_q;
    err_d    = err_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win;
          addr_d  = req_addr[16*win +: 16];
          wdata_d = req_wdata[16*win +: 16];
          op_wr_d = req_we[win];
          timer_d = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (bus_ack) begin
          rdata_d = bus_rdata;
          state_d = DONE;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        rr_ptr_d = IW'((32'(grant_q) + 32'd1) % NUM_CORES);
        err_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      op_wr_q  <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      op_wr_q  <= op_wr_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
    end
  end

  // Strobes and responses decode from the registered state only, so reset clears them asynchronously.
  assign bus_re    = (state_q == BUS) && !op_wr_q;
  assign bus_we    = (state_q == BUS) && op_wr_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign rsp_rdy   = (state_q == DONE) ? (NUM_CORES'(1) << grant_q) : '0;
  assign rsp_err   = (state_q == DONE) && err_q;
  assign rsp_rdata = rdata_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter: responses are checked against a scoreboard queue.
module tb_mm_bus_arbiter;

  localparam int NC = 2;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] req_re, req_we;
  logic [16*NC-1:0] req_addr, req_wdata;
  logic [NC-1:0] rsp_rdy;
  logic          rsp_err;
  logic [15:0]   rsp_rdata, bus_addr, bus_wdata, bus_rdata;
  logic          bus_re, bus_we, bus_ack;
  logic [0:0]    grant_id;

  mm_bus_arbiter #(.NUM_CORES(NC), .TIMEOUT_CYC(64), .ERR_RDATA(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .req_re(req_re), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_rdy(rsp_rdy),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .bus_addr(bus_addr),
    .bus_re(bus_re), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .grant_id(grant_id)
  );

  typedef struct {
    int          core;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   strobe_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Response monitor: every rsp_rdy pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus_re || bus_we) strobe_cnt++;
    if (rsp_rdy != '0) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_rsp: got rsp_rdy %0h expected none", rsp_rdy);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_core", 32'(rsp_rdy), 32'(1) << e.core);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic [15:0] a, input logic [15:0] d);
    req_addr[16*c +: 16]  = a;
    req_wdata[16*c +: 16] = d;
  endtask

  // Waits for the strobe, checks the bus side, acks after 'dly' extra cycles, checks the response.
  task automatic ack_xact(input int core, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] rd,
                          input int dly, input bit drop);
    sb.push_back('{core: core, err: 1'b0, rdata: rd});
    strobe_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus_re || bus_we) break;
    end
    chk("strobe_seen", 32'(bus_re | bus_we), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(core));
    chk("bus_addr", 32'(bus_addr), 32'(a));
    chk("bus_we", 32'(bus_we), 32'(wr));
    chk("bus_re", 32'(bus_re), 32'(!wr));
    if (wr) chk("bus_wdata", 32'(bus_wdata), 32'(d));
    for (int k = 0; k < dly; k++) begin
      tick();
      chk("strobe_held", 32'(bus_re | bus_we), 32'd1);
    end
    bus_ack   = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    chk("rsp_rdy_pulse", 32'(rsp_rdy), 32'(1) << core);
    chk("strobe_cycles", 32'(strobe_cnt), 32'(dly + 1));
    if (drop) begin
      req_re[core] = 1'b0;
      req_we[core] = 1'b0;
    end
    tick();
    chk("rsp_rdy_single", 32'(rsp_rdy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_re = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    tick(); tick();
    chk("rst_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_strobes", 32'({bus_re, bus_we}), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: single read, ack on second BUS cycle
    set_core(0, 16'hC004, 16'h0000);
    req_re[0] = 1'b1;
    ack_xact(0, 1'b0, 16'hC004, 16'h0000, 16'h1234, 1, 1'b1);

    // T4: core1 read with no ack -> timeout after 64 strobe cycles
    set_core(1, 16'h8000, 16'h0000);
    req_re[1] = 1'b1;
    sb.push_back('{core: 1, err: 1'b1, rdata: 16'hFFFF});
    strobe_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (rsp_rdy != '0) break;
    end
    chk("to_rsp_rdy", 32'(rsp_rdy), 32'd2);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_strobe_cycles", 32'(strobe_cnt), 32'd64);
    req_re[1] = 1'b0;
    tick();
    chk("to_err_cleared", 32'(rsp_err), 32'd0);

    // T2: simultaneous writes, rr_ptr back at 0
    set_core(0, 16'h4010, 16'hAAAA);
    set_core(1, 16'h4020, 16'h5555);
    req_we = 2'b11;
    ack_xact(0, 1'b1, 16'h4010, 16'hAAAA, 16'h0BAD, 0, 1'b1);
    ack_xact(1, 1'b1, 16'h4020, 16'h5555, 16'h0BEE, 0, 1'b1);

    // T3: both cores hold read requests -> grants alternate
    set_core(0, 16'h6000, 16'h0000);
    set_core(1, 16'h7000, 16'h0000);
    req_re = 2'b11;
    ack_xact(0, 1'b0, 16'h6000, 16'h0000, 16'h1111, 0, 1'b0);
    ack_xact(1, 1'b0, 16'h7000, 16'h0000, 16'h2222, 0, 1'b0);
    ack_xact(0, 1'b0, 16'h6000, 16'h0000, 16'h3333, 0, 1'b1);
    ack_xact(1, 1'b0, 16'h7000, 16'h0000, 16'h4444, 0, 1'b1);

    // T6: spurious ack while idle, then re+we on core0 issues a write
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    chk("spur_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("spur_strobes", 32'({bus_re, bus_we}), 32'd0);
    set_core(0, 16'h9000, 16'hBEEF);
    req_re[0] = 1'b1;
    req_we[0] = 1'b1;
    ack_xact(0, 1'b1, 16'h9000, 16'hBEEF, 16'h5A5A, 2, 1'b1);

    // T5: reset during BUS on core1 (grant_id=1, rr_ptr=1 beforehand)
    set_core(1, 16'h5000, 16'h0000);
    req_re[1] = 1'b1;
    tick();
    chk("t5_bus_re", 32'(bus_re), 32'd1);
    chk("t5_grant", 32'(grant_id), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_strobes", 32'({bus_re, bus_we}), 32'd0);
    chk("t5_async_grant", 32'(grant_id), 32'd0);
    req_re = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t5_post_grant", 32'(grant_id), 32'd0);
    set_core(0, 16'hA000, 16'h0000);
    set_core(1, 16'hB000, 16'h0000);
    req_re = 2'b11;
    ack_xact(0, 1'b0, 16'hA000, 16'h0000, 16'h7777, 0, 1'b1);
    ack_xact(1, 1'b0, 16'hB000, 16'h0000, 16'h8888, 0, 1'b1);

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
